// File: rtl/regfile_wsel_sb.sv
// Register file with writeback destination/data selection, NUM_RD combinational
// read ports and a pending-write scoreboard that raises stall on operand hazards.
// Optional feature: define RF_BYPASS_EN to forward this cycle's committing write
// to the read ports and clear the matching stall in the same cycle.
module regfile_wsel_sb #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned LINK_REG = 7,
    parameter int unsigned PC_INC   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_sel,
    input  logic [NUM_RD-1:0]        rd_use,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic                     lbi,
    input  logic                     link,
    input  logic [ADDR_W-1:0]        rs_sel,
    input  logic [ADDR_W-1:0]        rd_dst,
    input  logic [DATA_W-1:0]        alu_data,
    input  logic [DATA_W-1:0]        imm,
    input  logic [DATA_W-1:0]        pc,
    input  logic                     pend_set,
    input  logic [ADDR_W-1:0]        pend_sel,
    output logic                     stall,
    output logic                     err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;
    logic              err_q;
    logic              err_d;

    logic              illegal_c;
    logic              commit_c;
    logic [ADDR_W-1:0] wr_dst_c;
    logic [DATA_W-1:0] wr_data_c;
    logic [NUM_RD-1:0] port_stall_c;

    // Writeback destination/data selection; link outranks lbi
    always_comb begin
        illegal_c = wr_en & lbi & link;
        commit_c  = wr_en & ~(lbi & link);
        wr_dst_c  = rd_dst;
        wr_data_c = alu_data;
        if (link) begin
            wr_dst_c  = ADDR_W'(LINK_REG);
            wr_data_c = pc + DATA_W'(PC_INC);
        end else if (lbi) begin
            wr_dst_c  = rs_sel;
            wr_data_c = imm;
        end
    end

    // Scoreboard next state: a commit clears, a new producer mark wins over the clear
    always_comb begin
        pend_d = pend_q;
        if (commit_c) begin
            pend_d[wr_dst_c] = 1'b0;
        end
        if (pend_set) begin
            pend_d[pend_sel] = 1'b1;
        end
        err_d = illegal_c;
    end

    // Register array commit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit_c) begin
            regs_q[wr_dst_c] <= wr_data_c;
        end
    end

    // Scoreboard and error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    // Read ports and per-port hazard detection
    for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
        logic [ADDR_W-1:0] idx_c;
        logic [DATA_W-1:0] val_c;
        logic              hit_c;

        // Port k operand fetch and stall contribution
        always_comb begin
            idx_c = rd_sel[k*ADDR_W +: ADDR_W];
            val_c = regs_q[idx_c];
            hit_c = pend_q[idx_c];
`ifdef RF_BYPASS_EN
            if (commit_c && (idx_c == wr_dst_c)) begin
                val_c = wr_data_c;
                hit_c = 1'b0;
            end
`endif
            if (!rst) begin
                val_c = '0;
                hit_c = 1'b0;
            end
            rd_data[k*DATA_W +: DATA_W] = val_c;
            port_stall_c[k]             = hit_c & rd_use[k];
        end
    end

    assign stall = |port_stall_c;
    assign err   = err_q;

endmodule
